// File: rtl/m_piso_serializer_pkg.sv
// Shared definitions for the PISO serializer slice.
//   state_t : FSM state encoding (ST_IDLE = 1'b0, ST_SHIFT = 1'b1)
//   clog2   : counter width helper, usable in parameter expressions
package m_piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Number of bits needed to hold 0..value-1 (value >= 2 gives >= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/m_mod_counter.sv
// Modulo-MOD up-counter with synchronous clear and terminal-count flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear to 0, has priority over en
//   en         : advance by one; wraps MOD-1 -> 0
//   count      : current value, 0..MOD-1
//   tc         : high while count == MOD-1
module m_mod_counter
    import m_piso_serializer_pkg::*;
#(
    parameter int MOD = 8,
    parameter int CW  = clog2(MOD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    assign tc = (count == CW'(MOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/m_piso_serializer.sv
// Parallel-in / serial-out transmitter. A WIDTH-bit word taken over a
// valid/ready load handshake is shifted out one bit per clock; back-to-back
// words run without a gap.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_valid  : d_par holds a word to send
//   load_ready  : a word can be accepted this cycle
//   d_par       : parallel word, sampled only on an accepted load
//   d_out       : serial data bit (0 when idle)
//   out_valid   : d_out carries a data bit this cycle
//   busy        : a word is being shifted out (same as out_valid)
//   done        : one-cycle pulse with the last bit of each word
//
// Handshake: a load is accepted on a rising clk edge where load_valid and
// load_ready are both 1. load_ready depends only on state and bit count,
// never on load_valid; load_valid may be held high and waits for ready, and
// d_par is ignored whenever no load is accepted.
module m_piso_serializer
    import m_piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] d_par,
    output logic             d_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic             last_bit;
    logic             accept;

    assign accept = load_valid & load_ready;

    // Bit position of the word currently on d_out. Clearing on accept makes
    // a gapless reload restart at 0; otherwise it wraps to 0 as the word ends.
    m_mod_counter #(
        .MOD (WIDTH),
        .CW  (CW)
    ) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state == ST_SHIFT),
        .count (count),
        .tc    (last_bit)
    );

    // Ready in idle, and during the last bit so the next word follows with no gap.
    assign load_ready = (state == ST_IDLE) | ((state == ST_SHIFT) & last_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            shreg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_SHIFT;
                        shreg <= d_par;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        if (accept) begin
                            shreg <= d_par;
                        end else begin
                            state <= ST_IDLE;
                            shreg <= '0;
                        end
                    end else if (MSB_FIRST) begin
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg <= {1'b0, shreg[WIDTH-1:1]};
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    shreg <= '0;
                end
            endcase
        end
    end

    assign busy      = (state == ST_SHIFT);
    assign out_valid = busy;
    assign d_out     = busy & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign done      = busy & (count == CW'(WIDTH - 1));

endmodule

// File: tb/tb_m_piso_serializer.sv
// Bench for m_piso_serializer: three instances (8-bit MSB-first, 8-bit
// LSB-first, 5-bit MSB-first) sharing clk and rst_n. Inputs are driven and
// outputs sampled on the falling edge.
module tb_m_piso_serializer;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       lv_a = 1'b0, rdy_a, do_a, ov_a, busy_a, done_a;
    logic [7:0] dp_a = '0;
    logic       lv_b = 1'b0, rdy_b, do_b, ov_b, busy_b, done_b;
    logic [7:0] dp_b = '0;
    logic       lv_c = 1'b0, rdy_c, do_c, ov_c, busy_c, done_c;
    logic [4:0] dp_c = '0;

    m_piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .load_valid(lv_a), .load_ready(rdy_a), .d_par(dp_a),
        .d_out(do_a), .out_valid(ov_a), .busy(busy_a), .done(done_a));

    m_piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .load_valid(lv_b), .load_ready(rdy_b), .d_par(dp_b),
        .d_out(do_b), .out_valid(ov_b), .busy(busy_b), .done(done_b));

    m_piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .load_valid(lv_c), .load_ready(rdy_c), .d_par(dp_c),
        .d_out(do_c), .out_valid(ov_c), .busy(busy_c), .done(done_c));

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Sends w0 on instance A (and w1 back-to-back when n_words == 2, with
    // load_valid raised from bit index assert_at). Checks every bit against
    // the hand-expected MSB-first stream. Stops after bit stop_at if >= 0.
    task automatic stream_a(input logic [7:0] w0, input logic [7:0] w1,
                            input int n_words, input int assert_at, input int stop_at);
        logic [7:0] word;
        bit         stopped;
        stopped = 1'b0;
        lv_a = 1'b1;
        dp_a = w0;
        @(negedge clk);
        lv_a = 1'b0;
        dp_a = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8 * n_words; i++) begin
            word = (i < 8) ? w0 : w1;
            check("a_dout",  32'(do_a),   32'(word[7 - (i % 8)]));
            check("a_valid", 32'(ov_a),   32'd1);
            check("a_busy",  32'(busy_a), 32'd1);
            check("a_done",  32'(done_a), 32'((i % 8) == 7));
            check("a_ready", 32'(rdy_a),  32'((i % 8) == 7));
            if (i == stop_at) begin
                stopped = 1'b1;
                break;
            end
            if (n_words == 2 && i >= assert_at && i <= 7) begin
                lv_a = 1'b1;
                dp_a = w1;
            end else begin
                lv_a = 1'b0;
                dp_a = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
        end
        if (!stopped) begin
            check("a_idle_dout",  32'(do_a),   32'd0);
            check("a_idle_valid", 32'(ov_a),   32'd0);
            check("a_idle_busy",  32'(busy_a), 32'd0);
            check("a_idle_done",  32'(done_a), 32'd0);
            check("a_idle_ready", 32'(rdy_a),  32'd1);
        end
    endtask

    // Random words with random gaps on instance A (w=8) or C (w=5), both
    // MSB-first. A small model of the handshake decides which loads are
    // accepted; a SIPO rebuilds each word from the serial stream.
    task automatic rand_run(input int w, input int n_words);
        int         pushed, bits, guard, m_cnt;
        logic       m_busy, m_rdy, lv;
        logic       o_do, o_ov, o_done, o_rdy;
        logic [7:0] sipo, dp, mask;
        pushed = 0; bits = 0; guard = 0; m_cnt = 0;
        m_busy = 1'b0; sipo = '0;
        mask   = 8'((1 << w) - 1);
        exp_q.delete();
        while ((pushed < n_words || exp_q.size() != 0 || m_busy) && guard < 20000) begin
            if (w == 8) begin
                o_do = do_a; o_ov = ov_a; o_done = done_a; o_rdy = rdy_a;
            end else begin
                o_do = do_c; o_ov = ov_c; o_done = done_c; o_rdy = rdy_c;
            end
            m_rdy = !m_busy || (m_cnt == w - 1);
            check("rand_ready", 32'(o_rdy), 32'(m_rdy));
            check("rand_valid", 32'(o_ov),  32'(m_busy));
            if (!o_ov) begin
                check("rand_idle_dout", 32'(o_do), 32'd0);
            end else begin
                check("rand_done", 32'(o_done), 32'(bits == w - 1));
                sipo = {sipo[6:0], o_do};
                bits++;
                if (bits == w) begin
                    if (exp_q.size() == 0) check("rand_extra_word", 32'(sipo & mask), 32'hFFFF_FFFF);
                    else                   check("rand_word", 32'(sipo & mask), 32'(exp_q.pop_front()));
                    bits = 0;
                end
            end
            lv = (pushed < n_words) && ($urandom_range(0, 3) != 0);
            dp = 8'($urandom_range(0, 255)) & mask;
            if (w == 8) begin
                lv_a = lv; dp_a = dp;
            end else begin
                lv_c = lv; dp_c = dp[4:0];
            end
            if (lv && m_rdy) begin
                exp_q.push_back(dp);
                pushed++;
                m_busy = 1'b1;
                m_cnt  = 0;
            end else if (m_busy) begin
                if (m_cnt == w - 1) begin
                    m_busy = 1'b0;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end
            @(negedge clk);
            guard++;
        end
        lv_a = 1'b0;
        lv_c = 1'b0;
        if (guard >= 20000) check("rand_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] sipo_b;

        // Reset values, checked while rst_n is low.
        #2 rst_n = 1'b0;
        #1;
        check("rst_dout_a",  32'(do_a),   32'd0);
        check("rst_valid_a", 32'(ov_a),   32'd0);
        check("rst_busy_a",  32'(busy_a), 32'd0);
        check("rst_done_a",  32'(done_a), 32'd0);
        check("rst_ready_a", 32'(rdy_a),  32'd1);
        check("rst_ready_b", 32'(rdy_b),  32'd1);
        check("rst_valid_c", 32'(ov_c),   32'd0);
        check("rst_ready_c", 32'(rdy_c),  32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word A5, MSB first: 1,0,1,0,0,1,0,1 then idle.
        stream_a(8'hA5, 8'h00, 1, 0, -1);

        // Back-to-back A5 then 3C with load_valid held throughout.
        stream_a(8'hA5, 8'h3C, 2, 0, -1);

        // Load of FF raised at count 3 while 00 is sent: taken only at count 7.
        stream_a(8'h00, 8'hFF, 2, 3, -1);

        // LSB-first instance: 01 -> 1 then 0 x7, rebuilt by a right-shifting SIPO.
        lv_b   = 1'b1;
        dp_b   = 8'h01;
        sipo_b = '0;
        @(negedge clk);
        lv_b = 1'b0;
        dp_b = 8'hFE;
        for (int i = 0; i < 8; i++) begin
            check("b_dout",  32'(do_b),   32'(i == 0));
            check("b_valid", 32'(ov_b),   32'd1);
            check("b_done",  32'(done_b), 32'(i == 7));
            if (ov_b) sipo_b = {do_b, sipo_b[7:1]};
            @(negedge clk);
        end
        check("b_word",       32'(sipo_b), 32'h01);
        check("b_idle_valid", 32'(ov_b),   32'd0);
        check("b_idle_busy",  32'(busy_b), 32'd0);

        // Reset between edges at count 4 of FF: outputs clear at once.
        stream_a(8'hFF, 8'h00, 1, 0, 4);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_dout",  32'(do_a),   32'd0);
        check("mid_rst_valid", 32'(ov_a),   32'd0);
        check("mid_rst_busy",  32'(busy_a), 32'd0);
        check("mid_rst_done",  32'(done_a), 32'd0);
        check("mid_rst_ready", 32'(rdy_a),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stream_a(8'h81, 8'h00, 1, 0, -1);

        // Random words on both widths.
        rand_run(8, 500);
        rand_run(5, 500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
